// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Sequences one SHA-256 compression per 16-word message block. It feeds an
//   external one-round-per-cycle round unit, then folds the round unit's
//   final working variables into the chained hash state H0..H7.
//   Ports:
//     clk, rst_n           clock; asynchronous active-low reset
//     init                 pulse: load the SHA-256 IV (accepted in IDLE/LOAD only)
//     msg_valid/msg_data   message words W0..W15; msg_ready is the handshake
//     busy, done           busy spans KICK..CAPTURE; done pulses when digest updates
//     digest               {H0..H7}, with H0 in the MSBs
//     ru_run               start pulse to the round unit, high in KICK
//     ru_delay             round-unit start delay, tied to 0
//     ru_init              {a..h} seed for the round unit (the current H)
//     ru_w, ru_k           W_t and K_t for the current round, 0 outside RUN
//     ru_state             {a..h} working variables returned by the round unit
module sha256_round_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              msg_valid,
  input  logic [DATA_W-1:0] msg_data,
  output logic              msg_ready,
  output logic              busy,
  output logic              done,
  output logic [255:0]      digest,
  output logic              ru_run,
  output logic [31:0]       ru_delay,
  output logic [255:0]      ru_init,
  output logic [31:0]       ru_w,
  output logic [31:0]       ru_k,
  input  logic [255:0]      ru_state
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, CAPTURE, DONE} state_t;

  // Packed so that index 7 is H0, which lands in digest[255:224].
  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  state_t            state;
  logic [15:0][31:0] win;   // win[0] is the oldest word, W_t during RUN
  logic [7:0][31:0]  h;
  logic [3:0]        wcnt;
  logic [5:0]        t;
  logic [31:0]       w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // W_{t+16} from the sliding window W_t..W_{t+15}.
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  assign msg_ready = (state == IDLE || state == LOAD) && !init;
  assign ru_w      = (state == RUN) ? win[0] : '0;
  assign ru_k      = (state == RUN) ? K[t]   : '0;
  assign ru_delay  = '0;
  assign ru_init   = h;
  assign digest    = h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      win    <= '0;
      h      <= '0;
      wcnt   <= '0;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ru_run <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (init) begin
            // init wins over a same-cycle word (msg_ready is low then).
            h     <= IV;
            wcnt  <= '0;
            state <= IDLE;
          end else if (msg_valid) begin
            win[wcnt] <= msg_data;
            wcnt      <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
              state  <= KICK;
              ru_run <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        KICK: begin
          ru_run <= 1'b0;
          t      <= '0;
          state  <= RUN;
        end
        RUN: begin
          win <= {w_new, win[15:1]};
          t   <= t + 6'd1;
          if (t == 6'd63) state <= CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + ru_state[32*i +: 32];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
//   Drives message blocks into sha256_round_ctrl, emulates the external
//   one-round-per-cycle round unit, and compares digests against FIPS 180-4
//   vectors and a block-level SHA-256 compression model.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, init, msg_valid;
  logic [31:0]  msg_data;
  logic         msg_ready, busy, done, ru_run;
  logic [255:0] digest, ru_init, ru_state;
  logic [31:0]  ru_delay, ru_w, ru_k;

  sha256_round_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .busy(busy), .done(done), .digest(digest), .ru_run(ru_run),
    .ru_delay(ru_delay), .ru_init(ru_init), .ru_w(ru_w), .ru_k(ru_k), .ru_state(ru_state));

  always #5 clk = ~clk;

  localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int checks = 0, failures = 0;
  int cyc = 0;

  // ---- SHA-256 reference arithmetic ----
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    {a, b, c, d, e, f, g, hh} = s;
    t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] b [16]);
    logic [31:0]  w [64];
    logic [255:0] s, r;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    s = hin;
    for (int i = 0; i < 64; i++) s = rnd(s, w[i], KT[i]);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + s[32*i +: 32];
    return r;
  endfunction

  // ---- external round unit: seeds on ru_run, then one round per cycle ----
  logic [255:0] st;
  int           rcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0; rcnt <= 0;
    end else if (ru_run) begin
      st <= ru_init; rcnt <= 64;
    end else if (rcnt > 0) begin
      st <= rnd(st, ru_w, ru_k); rcnt <= rcnt - 1;
    end
  end
  assign ru_state = st;

  always @(posedge clk) cyc <= cyc + 1;

  // ---- observation of handshake/timing, sampled mid-cycle ----
  int           run_cnt = 0, done_cnt = 0, run_cyc = -1, done_cyc = -1, stable_cnt = 0, kpos = 0, kmis = 0;
  logic [31:0]  first_k = '0, last_k = '0;
  logic [255:0] init0 = '0;
  always @(negedge clk) begin
    if (ru_run) begin run_cnt++; run_cyc = cyc; init0 = ru_init; kpos = 0; end
    if (busy && ru_init === init0) stable_cnt++;
    if (ru_k !== 32'h0) begin
      if (kpos == 0) first_k = ru_k;
      last_k = ru_k;
      if (kpos > 63 || ru_k !== KT[kpos]) kmis++;
      kpos++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends words 0..n-1 of b; gap is the percent chance of idling a cycle.
  // L returns the edge index that accepted the last word.
  task automatic send_block(input logic [31:0] b [16], input int n, input int gap, output int L);
    bit acc;
    int guard;
    L = -1;
    for (int i = 0; i < n; i++) begin
      acc = 0; guard = 0;
      while (!acc && guard < 200) begin
        @(posedge clk); #1;
        msg_valid = ($urandom_range(99) >= gap);
        msg_data  = msg_valid ? b[i] : $urandom;
        @(negedge clk);
        acc = msg_valid && msg_ready;
        if (acc) L = cyc + 1;
        guard++;
      end
      chk("word_accept", {255'd0, acc}, 256'd1);
    end
    @(posedge clk); #1 msg_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (done_cnt > start);
    end
    chk("done_seen", {255'd0, ok}, 256'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_init;
    @(posedge clk); #1 init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
  endtask

  logic [31:0]  abc [16], emp [16], m1 [16], m2 [16], rb [16];
  logic [255:0] exp_h;
  int           L, dc;

  initial begin
    for (int i = 0; i < 16; i++) begin abc[i] = '0; emp[i] = '0; m2[i] = '0; end
    abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    emp[0] = 32'h80000000;
    m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
           32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m2[15] = 32'h000001c0;

    rst_n = 1'b0; init = 1'b0; msg_valid = 1'b0; msg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {255'd0, msg_ready}, 256'd1);
    chk("rst_outs",   {250'd0, busy, done, ru_run, |ru_delay, |ru_w, |ru_k}, 256'd0);
    chk("rst_digest", digest, 256'd0);
    chk("rst_ruinit", ru_init, 256'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    pulse_init;
    @(negedge clk);
    chk("init_iv", digest, IV);

    // "abc" with full-rate stream: latency, ru_run, K endpoints, ru_init stability
    run_cnt = 0; stable_cnt = 0; kmis = 0; dc = done_cnt;
    send_block(abc, 16, 0, L);
    msg_valid = 1'b1; msg_data = 32'hdeadbeef;   // must be ignored while busy
    @(negedge clk);
    chk("busy_ready", {254'd0, msg_ready, busy}, 256'd1);
    @(posedge clk); #1 msg_valid = 1'b0;
    wait_done(dc);
    chk("abc_digest",  digest, D_ABC);
    chk("abc_run_cyc", 256'(run_cyc), 256'(L));
    chk("abc_done_cyc", 256'(done_cyc), 256'(L + 66));
    chk("abc_run_cnt", 256'(run_cnt), 256'd1);
    chk("abc_done_cnt", 256'(done_cnt - dc), 256'd1);
    chk("abc_k_first", {224'd0, first_k}, {224'd0, 32'h428a2f98});
    chk("abc_k_last",  {224'd0, last_k},  {224'd0, 32'hc67178f2});
    chk("abc_k_rom",   256'(kmis), 256'd0);
    chk("abc_stable",  256'(stable_cnt), 256'd66);
    @(negedge clk);
    chk("idle_outs", {253'd0, busy, |ru_w, |ru_k}, 256'd0);

    // empty string: random gaps, init during RUN must be ignored
    pulse_init;
    dc = done_cnt;
    send_block(emp, 16, 40, L);
    repeat (10) @(posedge clk);
    pulse_init;
    wait_done(dc);
    chk("emp_digest", digest, D_EMP);

    // init in LOAD with a word offered the same cycle, then "abc" with gaps
    send_block(abc, 5, 30, L);
    init = 1'b1; msg_valid = 1'b1; msg_data = 32'h12345678;
    @(negedge clk);
    chk("init_blocks_ready", {255'd0, msg_ready}, 256'd0);
    @(posedge clk); #1 init = 1'b0; msg_valid = 1'b0;
    dc = done_cnt;
    send_block(abc, 16, 40, L);
    repeat (20) @(posedge clk);
    pulse_init;
    wait_done(dc);
    chk("abc_gap_digest", digest, D_ABC);

    // two chained blocks, init in RUN of the second
    pulse_init;
    dc = done_cnt;
    send_block(m1, 16, 0, L);
    wait_done(dc);
    chk("two_mid", digest, compress(IV, m1));
    dc = done_cnt;
    send_block(m2, 16, 0, L);
    repeat (30) @(posedge clk);
    pulse_init;
    wait_done(dc);
    chk("two_final", digest, D_TWO);

    // random chained blocks against the model
    exp_h = D_TWO;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) rb[i] = $urandom;
      exp_h = compress(exp_h, rb);
      dc = done_cnt;
      send_block(rb, 16, 25, L);
      wait_done(dc);
      chk("rand_digest", digest, exp_h);
    end

    // reset at round 30 discards the block
    pulse_init;
    send_block(abc, 16, 0, L);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    chk("mid_rst_digest", digest, 256'd0);
    chk("mid_rst_outs", {252'd0, msg_ready, busy, done, |ru_k}, 256'd8);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    chk("no_spurious_done", 256'(done_cnt), 256'(dc));
    pulse_init;
    dc = done_cnt;
    send_block(abc, 16, 0, L);
    wait_done(dc);
    chk("post_rst_abc", digest, D_ABC);
    chk("post_rst_done_cyc", 256'(done_cyc), 256'(L + 66));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
